// File: rtl/collision_hp_tracker.sv
// ============================================================================
// Module  : collision_hp_tracker
// Brief   : Per-frame player/obstacle overlap counter driving HP, i-frames,
//           sprite blink and game-over.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_hp_tracker #(
    parameter int HP_MAX      = 20,
    parameter int DAMAGE      = 1,
    parameter int MIN_OVERLAP = 4,
    parameter int IFRAMES     = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_frame_tick,
    input  logic       i_pixel_valid,
    input  logic       i_draw_player,
    input  logic       i_draw_obstacle,
    input  logic       i_restart,
    output logic [7:0] o_hp,
    output logic       o_hit_pulse,
    output logic       o_invuln,
    output logic       o_game_over,
    output logic       o_player_visible
);

    localparam logic [7:0] C_HP_MAX      = 8'(HP_MAX);
    localparam logic [7:0] C_DAMAGE      = 8'(DAMAGE);
    localparam logic [7:0] C_MIN_OVERLAP = 8'(MIN_OVERLAP);
    localparam logic [7:0] C_IFRAMES     = 8'(IFRAMES);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_overlap_cnt;
    logic [7:0] r_iframe_cnt;
    logic [7:0] w_iframe_nx;
    logic [7:0] w_hp_nx;
    logic [7:0] w_new_hp;
    logic [2:0] r_blink_cnt;
    logic [2:0] w_blink_nx;
    logic       w_hit_nx;
    logic       w_vis_nx;
    logic       w_overlap_px;
    logic [8:0] w_overlap_sum;
    logic       w_hit_now;

    always_comb begin
        w_overlap_px  = i_pixel_valid & i_draw_player & i_draw_obstacle;
        // A pixel coincident with the tick still belongs to the ending frame.
        w_overlap_sum = {1'b0, r_overlap_cnt} + {8'd0, w_overlap_px};
        w_hit_now     = (w_overlap_sum >= {1'b0, C_MIN_OVERLAP});
        w_new_hp      = (o_hp <= C_DAMAGE) ? 8'd0 : (o_hp - C_DAMAGE);

        w_state_nx  = r_state;
        w_hp_nx     = o_hp;
        w_iframe_nx = r_iframe_cnt;
        w_blink_nx  = r_blink_cnt;
        w_hit_nx    = 1'b0;

        if (i_frame_tick) begin
            w_blink_nx = r_blink_cnt + 3'd1;
            if (i_restart) begin
                w_state_nx  = ST_ALIVE;
                w_hp_nx     = C_HP_MAX;
                w_iframe_nx = 8'd0;
            end else begin
                case (r_state)
                    ST_ALIVE: begin
                        if (w_hit_now) begin
                            w_hit_nx = 1'b1;
                            w_hp_nx  = w_new_hp;
                            if (w_new_hp == 8'd0) begin
                                w_state_nx  = ST_DEAD;
                                w_iframe_nx = 8'd0;
                            end else begin
                                w_state_nx  = ST_INVULN;
                                w_iframe_nx = C_IFRAMES;
                            end
                        end
                    end
                    ST_INVULN: begin
                        if (r_iframe_cnt <= 8'd1) begin
                            w_state_nx  = ST_ALIVE;
                            w_iframe_nx = 8'd0;
                        end else begin
                            w_iframe_nx = r_iframe_cnt - 8'd1;
                        end
                    end
                    ST_DEAD: begin
                        w_hp_nx = 8'd0;
                    end
                    default: begin
                        w_state_nx = ST_ALIVE;
                    end
                endcase
            end
        end

        case (w_state_nx)
            ST_ALIVE:  w_vis_nx = 1'b1;
            ST_INVULN: w_vis_nx = ~w_blink_nx[2];
            default:   w_vis_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_ALIVE;
            r_overlap_cnt    <= 8'd0;
            r_iframe_cnt     <= 8'd0;
            r_blink_cnt      <= 3'd0;
            o_hp             <= C_HP_MAX;
            o_hit_pulse      <= 1'b0;
            o_invuln         <= 1'b0;
            o_game_over      <= 1'b0;
            o_player_visible <= 1'b1;
        end else begin
            if (i_frame_tick) begin
                r_overlap_cnt <= 8'd0;
            end else if (w_overlap_px && (r_overlap_cnt != 8'hFF)) begin
                r_overlap_cnt <= r_overlap_cnt + 8'd1;
            end
            r_state          <= w_state_nx;
            r_iframe_cnt     <= w_iframe_nx;
            r_blink_cnt      <= w_blink_nx;
            o_hp             <= w_hp_nx;
            o_hit_pulse      <= w_hit_nx;
            o_invuln         <= (w_state_nx == ST_INVULN);
            o_game_over      <= (w_state_nx == ST_DEAD);
            o_player_visible <= w_vis_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_collision_hp_tracker.sv
// ============================================================================
// Module  : tb_collision_hp_tracker
// Brief   : Directed vector bench for collision_hp_tracker (default and DAMAGE=7).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_hp_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pixel_valid = 1'b0;
    logic       draw_player = 1'b0;
    logic       draw_obstacle = 1'b0;
    logic       restart = 1'b0;

    logic [7:0] hp, hp7;
    logic       hit, hit7, inv, inv7, go, go7, vis, vis7;

    int total = 0;
    int bad   = 0;
    int ticks = 0;

    always #5 clk = ~clk;

    collision_hp_tracker dut (
        .clk(clk), .reset(reset), .i_frame_tick(frame_tick),
        .i_pixel_valid(pixel_valid), .i_draw_player(draw_player),
        .i_draw_obstacle(draw_obstacle), .i_restart(restart),
        .o_hp(hp), .o_hit_pulse(hit), .o_invuln(inv),
        .o_game_over(go), .o_player_visible(vis)
    );

    collision_hp_tracker #(.HP_MAX(20), .DAMAGE(7), .MIN_OVERLAP(4), .IFRAMES(30)) dut7 (
        .clk(clk), .reset(reset), .i_frame_tick(frame_tick),
        .i_pixel_valid(pixel_valid), .i_draw_player(draw_player),
        .i_draw_obstacle(draw_obstacle), .i_restart(restart),
        .o_hp(hp7), .o_hit_pulse(hit7), .o_invuln(inv7),
        .o_game_over(go7), .o_player_visible(vis7)
    );

    typedef struct {
        int n;
        bit tp;
        bit rs;
        int hp;
        bit inv;
        bit hit;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic vis_exp(input logic in_inv);
        logic [31:0] t;
        t = ticks;
        return in_inv ? ~t[2] : 1'b1;
    endfunction

    // One frame: n overlap pixels, a few non-overlap pixels, blanking, then the tick.
    task automatic frame(input int n, input bit tp, input bit rs);
        restart = rs;
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1; draw_player = 1'b1; draw_obstacle = 1'b1;
            step();
        end
        pixel_valid = 1'b1; draw_player = 1'b1; draw_obstacle = 1'b0;
        step();
        step();
        pixel_valid = 1'b0; draw_player = 1'b0;
        step();
        frame_tick = 1'b1; pixel_valid = tp; draw_player = tp; draw_obstacle = tp;
        step();
        frame_tick = 1'b0; pixel_valid = 1'b0; draw_player = 1'b0;
        draw_obstacle = 1'b0; restart = 1'b0;
        ticks++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        ticks = 0;
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 10; i++) tbl[i] = '{0, 1'b0, 1'b0, 20, 1'b0, 1'b0};
        tbl[10] = '{3, 1'b0, 1'b0, 20, 1'b0, 1'b0};
        tbl[11] = '{3, 1'b1, 1'b0, 19, 1'b1, 1'b1};

        apply_reset();
        chk("rst_hp", hp, 20);
        chk("rst_inv", inv, 0);
        chk("rst_go", go, 0);
        chk("rst_vis", vis, 1);
        chk("rst_hit", hit, 0);

        for (int v = 0; v < 12; v++) begin
            frame(tbl[v].n, tbl[v].tp, tbl[v].rs);
            chk($sformatf("v%0d_hp", v), hp, tbl[v].hp);
            chk($sformatf("v%0d_inv", v), inv, tbl[v].inv);
            chk($sformatf("v%0d_hit", v), hit, tbl[v].hit);
            chk($sformatf("v%0d_vis", v), vis, vis_exp(tbl[v].inv));
        end
        step();
        chk("hit_one_cycle", hit, 0);

        // Continuous overlap through the invulnerability window.
        for (int k = 1; k <= 29; k++) begin
            frame(4, 1'b0, 1'b0);
            chk($sformatf("if%0d_hp", k), hp, 19);
            chk($sformatf("if%0d_inv", k), inv, 1);
            chk($sformatf("if%0d_hit", k), hit, 0);
            chk($sformatf("if%0d_vis", k), vis, vis_exp(1'b1));
        end
        frame(4, 1'b0, 1'b0);
        chk("exp_hp", hp, 19);
        chk("exp_inv", inv, 0);
        chk("exp_hit", hit, 0);
        chk("exp_vis", vis, 1);
        frame(4, 1'b0, 1'b0);
        chk("rehit_hp", hp, 18);
        chk("rehit_hit", hit, 1);
        chk("rehit_inv", inv, 1);

        for (int k = 0; k < 30; k++) frame(0, 1'b0, 1'b0);
        chk("wait_inv", inv, 0);
        frame(5, 1'b0, 1'b1);
        chk("rs_hit_hp", hp, 20);
        chk("rs_hit_hit", hit, 0);
        chk("rs_hit_inv", inv, 0);

        // 256 pixels would wrap an unsaturated 8-bit counter back to zero.
        frame(256, 1'b0, 1'b0);
        chk("sat_hp", hp, 19);
        chk("sat_hit", hit, 1);
        step();
        chk("sat_hit_once", hit, 0);

        // Async reset in the middle of an INVULN frame with 100 pixels counted.
        for (int i = 0; i < 100; i++) begin
            pixel_valid = 1'b1; draw_player = 1'b1; draw_obstacle = 1'b1;
            step();
        end
        pixel_valid = 1'b0; draw_player = 1'b0; draw_obstacle = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_hp", hp, 20);
        chk("arst_inv", inv, 0);
        chk("arst_vis", vis, 1);
        step();
        reset = 1'b0;
        ticks = 0;
        step();
        frame(3, 1'b0, 1'b0);
        chk("arst_cnt_hp", hp, 20);
        chk("arst_cnt_hit", hit, 0);

        // DAMAGE=7 instance: 20 -> 13 -> 6 -> 0.
        apply_reset();
        frame(4, 1'b0, 1'b0);
        chk("d7_h1_hp", hp7, 13);
        chk("d7_h1_hit", hit7, 1);
        for (int k = 0; k < 30; k++) frame(0, 1'b0, 1'b0);
        frame(4, 1'b0, 1'b0);
        chk("d7_h2_hp", hp7, 6);
        for (int k = 0; k < 30; k++) frame(0, 1'b0, 1'b0);
        frame(4, 1'b0, 1'b0);
        chk("d7_h3_hp", hp7, 0);
        chk("d7_h3_hit", hit7, 1);
        chk("d7_h3_go", go7, 1);
        chk("d7_h3_vis", vis7, 0);
        chk("d7_h3_inv", inv7, 0);
        frame(10, 1'b1, 1'b0);
        chk("dead_hp", hp7, 0);
        chk("dead_hit", hit7, 0);
        chk("dead_go", go7, 1);

        restart = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("dead_rs_mid_go", go7, 1);
        chk("dead_rs_mid_hp", hp7, 0);
        frame(0, 1'b0, 1'b1);
        chk("dead_rs_hp", hp7, 20);
        chk("dead_rs_go", go7, 0);
        chk("dead_rs_vis", vis7, 1);
        chk("dead_rs_hit", hit7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
